pq_ui_ctl: RTL and testbench
============================

PQ_UI_CTL -- requirements
Module: pq_ui_ctl

Interface
REQ-001 SHALL have parameters: KEY_W, default 4, key width; DEPTH, default 8, queue capacity; DB_CYCLES, default 500000, debounce stable count; DISP_CYCLES, default 100000000, result hold time; AUTO_PERIOD, default 50000000, auto-op spacing.
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- btn_start, btn_add, btn_remove  in  1 each  raw pushbuttons
- sw_key  in  KEY_W  manual key
- pq_push, pq_pop  out  1  single-cycle core commands
- pq_key  out  KEY_W  push key
- pq_done  in  1  core op complete
- pq_dout  in  KEY_W  popped key, valid with pq_done
- pq_full, pq_empty  in  1  core status
- rgb_r, rgb_g, rgb_b  out  3 each  PWM levels
- disp_in, disp_out  out  KEY_W  last pushed / popped key
- disp_cnt  out  $clog2(DEPTH+1)  occupancy
- sigIDLE, sigSTART, sigADD, sigREMOVE, sigDISPLAY, sigFULL, sigEMPTY  out  1  status
REQ-003 SHALL use one clock; reset synchronous, active-high.

Function
REQ-004 Each raw button SHALL be debounced (DB_CYCLES stable samples) then reduced to a one-cycle pulse on its rising edge.
REQ-005 FSM states: IDLE, ADD, REMOVE, WAIT, DISPLAY, FULL, EMPTY; exactly one of sigIDLE/sigADD/sigREMOVE/sigDISPLAY/sigFULL/sigEMPTY high per state (WAIT drives sigADD or sigREMOVE per pending op).
REQ-006 IDLE: remove pulse with !pq_empty -> REMOVE; remove pulse with pq_empty -> EMPTY; else add pulse with !pq_full -> ADD; add pulse with pq_full -> FULL.
REQ-007 Simultaneous add and remove pulses SHALL resolve as remove; the add is dropped.
REQ-008 ADD SHALL assert pq_push for exactly one cycle with pq_key = selected key, then go to WAIT.
REQ-009 REMOVE SHALL assert pq_pop for exactly one cycle, then go to WAIT.
REQ-010 WAIT SHALL hold until pq_done; on that cycle disp_in <= pq_key (push) or disp_out <= pq_dout (pop), disp_cnt +1 / -1, then DISPLAY.
REQ-011 disp_cnt SHALL saturate at 0 and DEPTH.
REQ-012 DISPLAY, FULL, EMPTY SHALL each hold exactly DISP_CYCLES cycles, then return to IDLE.
REQ-013 Button pulses arriving outside IDLE SHALL be discarded, not queued.
REQ-014 RGB levels: IDLE 0/0/1; ADD+WAIT(push) 0/7/0; REMOVE+WAIT(pop) 0/0/7; DISPLAY 0/4/0; FULL 7/0/0; EMPTY 7/0/7 (r/g/b).
REQ-015 pq_key SHALL equal sw_key in manual operation, sampled on entry to ADD.

Reset
REQ-016 On rst: state IDLE, pq_push=pq_pop=0, pq_key=0, disp_in=disp_out=0, disp_cnt=0, sigIDLE=1, other sig*=0, rgb=0/0/1, all timers, debouncers and LFSR reinitialised (LFSR seed all-ones).
REQ-017 rst during WAIT SHALL abandon the op; a later pq_done SHALL be ignored outside WAIT.

Configuration
REQ-018 Macro PQ_AUTO_EN: when defined, a start pulse in IDLE toggles auto_run (sigSTART = auto_run); while auto_run, every AUTO_PERIOD cycles in IDLE issue ADD with a KEY_W-bit maximal LFSR key until pq_full, then REMOVE until pq_empty, then clear auto_run; add/remove buttons ignored while auto_run.
REQ-019 Without PQ_AUTO_EN: btn_start is unused, sigSTART tied 0, no LFSR logic synthesised.

Structure
REQ-020 pq_pkg SHALL hold the FSM state enum typedef, RGB level constants, and parameter defaults.
REQ-021 Debounce plus single-pulse SHALL be one sub-module, pq_btn_cond, instantiated per button.

Verification
REQ-022 DB_CYCLES=4, DISP_CYCLES=8: sw_key=5, add pressed, pq_done 3 cycles after push -> one-cycle pq_push key 5, disp_in=5, disp_cnt=1, sigDISPLAY 8 cycles, back to IDLE.
REQ-023 Button bounce shorter than 4 cycles -> no pq_push; stable 10-cycle press -> exactly one pq_push.
REQ-024 pq_full=1, add pressed -> no pq_push, sigFULL 8 cycles, rgb 7/0/0; pq_empty=1, remove -> sigEMPTY, rgb 7/0/7.
REQ-025 add and remove pulses same cycle, queue non-empty -> one pq_pop, no pq_push, disp_cnt decrements.
REQ-026 PQ_AUTO_EN, DEPTH=4, AUTO_PERIOD=16: start pressed -> 4 pushes, 4 pops with nondecreasing disp_out from a min-core model, auto_run clears, sigSTART falls.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared state encoding, LED levels, parameter defaults and the LFSR tap table
// for the priority-queue pushbutton front end.
package pq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADD,
      ST_REMOVE,
      ST_WAIT,
      ST_DISPLAY,
      ST_FULL,
      ST_EMPTY
   } pq_state_e;

   localparam logic [2:0] RGB_OFF = 3'd0;
   localparam logic [2:0] RGB_DIM = 3'd1;
   localparam logic [2:0] RGB_MID = 3'd4;
   localparam logic [2:0] RGB_MAX = 3'd7;

   localparam int KEY_W_DEF       = 4;
   localparam int DEPTH_DEF       = 8;
   localparam int DB_CYCLES_DEF   = 500000;
   localparam int DISP_CYCLES_DEF = 100000000;
   localparam int AUTO_PERIOD_DEF = 50000000;

   // Feedback taps (bit mask, bit 0 = LSB) for a maximal-length shift-left
   // Fibonacci LFSR of the given width.
   function automatic logic [31:0] lfsr_taps(input int width);
      case (width)
         2:       return 32'h0000_0003;
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         default: return 32'h0000_0003;
      endcase
   endfunction

endpackage

// File: rtl/pq_btn_cond.sv
// Raw pushbutton conditioner: two-flop synchroniser, stability debounce and a
// one-cycle pulse on each debounced rising edge.
module pq_btn_cond #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          stable_q;
   logic [CW-1:0] cnt_q;

   // The debounced level only moves after DB_CYCLES consecutive samples that
   // disagree with it; any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         cnt_q    <= CNT_LOAD;
         pulse    <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn};
         pulse  <= 1'b0;
         if (sync_q[1] == stable_q) begin
            cnt_q <= CNT_LOAD;
         end else if (cnt_q == '0) begin
            stable_q <= sync_q[1];
            cnt_q    <= CNT_LOAD;
            pulse    <= sync_q[1];
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/pq_ui_ctl.sv
// Pushbutton / LED front end for a min-priority-queue core.
// Define PQ_AUTO_EN to add the start-button driven LFSR fill/drain demo.
//
// state      | meaning
// IDLE       | waiting for a button pulse (or an auto tick)
// ADD        | one-cycle pq_push with the latched key
// REMOVE     | one-cycle pq_pop
// WAIT       | core busy; op_pop_q tells which op is pending
// DISPLAY    | result shown for DISP_CYCLES cycles
// FULL       | push refused, shown for DISP_CYCLES cycles
// EMPTY      | pop refused, shown for DISP_CYCLES cycles
module pq_ui_ctl
   import pq_pkg::*;
#(
   parameter int KEY_W       = KEY_W_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int DB_CYCLES   = DB_CYCLES_DEF,
   parameter int DISP_CYCLES = DISP_CYCLES_DEF,
   parameter int AUTO_PERIOD = AUTO_PERIOD_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       btn_start,
   input  logic                       btn_add,
   input  logic                       btn_remove,
   input  logic [KEY_W-1:0]           sw_key,
   output logic                       pq_push,
   output logic                       pq_pop,
   output logic [KEY_W-1:0]           pq_key,
   input  logic                       pq_done,
   input  logic [KEY_W-1:0]           pq_dout,
   input  logic                       pq_full,
   input  logic                       pq_empty,
   output logic [2:0]                 rgb_r,
   output logic [2:0]                 rgb_g,
   output logic [2:0]                 rgb_b,
   output logic [KEY_W-1:0]           disp_in,
   output logic [KEY_W-1:0]           disp_out,
   output logic [$clog2(DEPTH+1)-1:0] disp_cnt,
   output logic                       sigIDLE,
   output logic                       sigSTART,
   output logic                       sigADD,
   output logic                       sigREMOVE,
   output logic                       sigDISPLAY,
   output logic                       sigFULL,
   output logic                       sigEMPTY
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int DT_W  = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
   localparam logic [DT_W-1:0]  DISP_LOAD = DT_W'(DISP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEPTH);

   pq_state_e        state_q, state_d;
   logic             op_pop_q, op_pop_d;
   logic             key_load;
   logic [DT_W-1:0]  disp_tmr_q;
   logic             add_p, rm_p;
   logic             manual_en;
   logic             auto_add, auto_rm;
   logic [KEY_W-1:0] auto_key;

   pq_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_add (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_add),
      .pulse (add_p)
   );

   pq_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_remove (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_remove),
      .pulse (rm_p)
   );

`ifdef PQ_AUTO_EN
   localparam int AT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   localparam logic [AT_W-1:0]  AUTO_LOAD = AT_W'(AUTO_PERIOD - 1);
   localparam logic [KEY_W-1:0] TAPS      = KEY_W'(lfsr_taps(KEY_W));

   logic             start_p;
   logic             auto_run_q;
   logic             drain_q;
   logic [AT_W-1:0]  auto_tmr_q;
   logic [KEY_W-1:0] lfsr_q;
   logic             auto_tick;

   pq_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_start (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_start),
      .pulse (start_p)
   );

   assign auto_tick = auto_run_q && (state_q == ST_IDLE) && !start_p && (auto_tmr_q == '0);
   assign auto_add  = auto_tick && !drain_q && !pq_full;
   assign auto_rm   = auto_tick && !auto_add && !pq_empty;
   assign auto_key  = lfsr_q;
   assign manual_en = !auto_run_q && !start_p;
   assign sigSTART  = auto_run_q;

   // Fill until the core reports full, then drain until empty, then stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         auto_run_q <= 1'b0;
         drain_q    <= 1'b0;
         auto_tmr_q <= AUTO_LOAD;
         lfsr_q     <= '1;
      end else if ((state_q == ST_IDLE) && start_p) begin
         auto_run_q <= !auto_run_q;
         drain_q    <= 1'b0;
         auto_tmr_q <= AUTO_LOAD;
      end else if (auto_run_q && (state_q == ST_IDLE)) begin
         if (auto_tmr_q != '0) begin
            auto_tmr_q <= auto_tmr_q - 1'b1;
         end else begin
            auto_tmr_q <= AUTO_LOAD;
            if (auto_add) begin
               lfsr_q <= {lfsr_q[KEY_W-2:0], ^(lfsr_q & TAPS)};
            end else if (auto_rm) begin
               drain_q <= 1'b1;
            end else begin
               auto_run_q <= 1'b0;
               drain_q    <= 1'b0;
            end
         end
      end
   end
`else
   logic unused_start;
   assign unused_start = btn_start;
   assign auto_add     = 1'b0;
   assign auto_rm      = 1'b0;
   assign auto_key     = '0;
   assign manual_en    = 1'b1;
   assign sigSTART     = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      op_pop_d = op_pop_q;
      key_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (auto_add) begin
               state_d  = ST_ADD;
               op_pop_d = 1'b0;
               key_load = 1'b1;
            end else if (auto_rm) begin
               state_d  = ST_REMOVE;
               op_pop_d = 1'b1;
            end else if (manual_en && rm_p) begin
               // remove wins over a coincident add
               state_d  = pq_empty ? ST_EMPTY : ST_REMOVE;
               op_pop_d = 1'b1;
            end else if (manual_en && add_p) begin
               state_d  = pq_full ? ST_FULL : ST_ADD;
               op_pop_d = 1'b0;
               key_load = !pq_full;
            end
         end
         ST_ADD:     state_d = ST_WAIT;
         ST_REMOVE:  state_d = ST_WAIT;
         ST_WAIT:    if (pq_done) state_d = ST_DISPLAY;
         ST_DISPLAY: if (disp_tmr_q == '0) state_d = ST_IDLE;
         ST_FULL:    if (disp_tmr_q == '0) state_d = ST_IDLE;
         ST_EMPTY:   if (disp_tmr_q == '0) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_pop_q   <= 1'b0;
         pq_key     <= '0;
         disp_in    <= '0;
         disp_out   <= '0;
         disp_cnt   <= '0;
         disp_tmr_q <= DISP_LOAD;
      end else begin
         state_q  <= state_d;
         op_pop_q <= op_pop_d;
         if (key_load) begin
            pq_key <= auto_add ? auto_key : sw_key;
         end
         if ((state_q == ST_WAIT) && pq_done) begin
            if (op_pop_q) begin
               disp_out <= pq_dout;
               if (disp_cnt != '0) disp_cnt <= disp_cnt - 1'b1;
            end else begin
               disp_in <= pq_key;
               if (disp_cnt != CNT_MAX) disp_cnt <= disp_cnt + 1'b1;
            end
         end
         // Hold-state timer: reloaded everywhere else, counted down while held.
         if (state_q inside {ST_DISPLAY, ST_FULL, ST_EMPTY}) begin
            if (disp_tmr_q != '0) disp_tmr_q <= disp_tmr_q - 1'b1;
         end else begin
            disp_tmr_q <= DISP_LOAD;
         end
      end
   end

   assign pq_push = (state_q == ST_ADD);
   assign pq_pop  = (state_q == ST_REMOVE);

   always_comb begin
      sigIDLE    = 1'b0;
      sigADD     = 1'b0;
      sigREMOVE  = 1'b0;
      sigDISPLAY = 1'b0;
      sigFULL    = 1'b0;
      sigEMPTY   = 1'b0;
      rgb_r      = RGB_OFF;
      rgb_g      = RGB_OFF;
      rgb_b      = RGB_OFF;
      case (state_q)
         ST_IDLE: begin
            sigIDLE = 1'b1;
            rgb_b   = RGB_DIM;
         end
         ST_ADD: begin
            sigADD = 1'b1;
            rgb_g  = RGB_MAX;
         end
         ST_REMOVE: begin
            sigREMOVE = 1'b1;
            rgb_b     = RGB_MAX;
         end
         ST_WAIT: begin
            if (op_pop_q) begin
               sigREMOVE = 1'b1;
               rgb_b     = RGB_MAX;
            end else begin
               sigADD = 1'b1;
               rgb_g  = RGB_MAX;
            end
         end
         ST_DISPLAY: begin
            sigDISPLAY = 1'b1;
            rgb_g      = RGB_MID;
         end
         ST_FULL: begin
            sigFULL = 1'b1;
            rgb_r   = RGB_MAX;
         end
         ST_EMPTY: begin
            sigEMPTY = 1'b1;
            rgb_r    = RGB_MAX;
            rgb_b    = RGB_MAX;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pq_ui_ctl.sv
// Bench for pq_ui_ctl: a min-queue core model answers push/pop, an event-level
// model predicts the display registers, and directed tests pin timing and LEDs.
`timescale 1ns/1ps
module tb_pq_ui_ctl;

   localparam int KEY_W  = 4;
   localparam int DEPTH  = 4;
   localparam int DB     = 4;
   localparam int DISP   = 8;
   localparam int AUTO_P = 16;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   localparam int S_IDLE = 0, S_ADD = 1, S_REMOVE = 2, S_DISPLAY = 3;
   localparam int S_FULL = 4, S_EMPTY = 5, S_START = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             btn_start = 1'b0, btn_add = 1'b0, btn_remove = 1'b0;
   logic [KEY_W-1:0] sw_key = '0;
   logic             pq_push, pq_pop;
   logic [KEY_W-1:0] pq_key;
   logic             pq_done = 1'b0;
   logic [KEY_W-1:0] pq_dout = '0;
   logic             pq_full, pq_empty;
   logic [2:0]       rgb_r, rgb_g, rgb_b;
   logic [KEY_W-1:0] disp_in, disp_out;
   logic [CNT_W-1:0] disp_cnt;
   logic             sigIDLE, sigSTART, sigADD, sigREMOVE, sigDISPLAY, sigFULL, sigEMPTY;

   always #5 clk = ~clk;

   pq_ui_ctl #(
      .KEY_W(KEY_W), .DEPTH(DEPTH), .DB_CYCLES(DB),
      .DISP_CYCLES(DISP), .AUTO_PERIOD(AUTO_P)
   ) dut (
      .clk(clk), .rst(rst),
      .btn_start(btn_start), .btn_add(btn_add), .btn_remove(btn_remove),
      .sw_key(sw_key),
      .pq_push(pq_push), .pq_pop(pq_pop), .pq_key(pq_key),
      .pq_done(pq_done), .pq_dout(pq_dout),
      .pq_full(pq_full), .pq_empty(pq_empty),
      .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
      .disp_in(disp_in), .disp_out(disp_out), .disp_cnt(disp_cnt),
      .sigIDLE(sigIDLE), .sigSTART(sigSTART), .sigADD(sigADD),
      .sigREMOVE(sigREMOVE), .sigDISPLAY(sigDISPLAY),
      .sigFULL(sigFULL), .sigEMPTY(sigEMPTY)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- min-queue core model ----------------
   int               core_q[$];
   int               core_n = 0;
   logic             core_busy = 1'b0;
   logic             core_push_op = 1'b0;
   int               core_lat = 0;
   logic [KEY_W-1:0] core_key = '0;
   logic             done_is_push = 1'b0;
   logic [KEY_W-1:0] done_key = '0;
   logic             force_full = 1'b0, force_empty = 1'b0;

   assign pq_full  = force_full || (core_n >= DEPTH);
   assign pq_empty = force_empty || (core_n == 0);

   function automatic int pop_min();
      int idx = 0;
      int v;
      if (core_q.size() == 0) return 0;
      for (int i = 1; i < core_q.size(); i++)
         if (core_q[i] < core_q[idx]) idx = i;
      v = core_q[idx];
      core_q.delete(idx);
      return v;
   endfunction

   always @(posedge clk) begin
      pq_done <= 1'b0;
      if (pq_push || pq_pop) begin
         core_busy    <= 1'b1;
         core_push_op <= pq_push;
         core_key     <= pq_key;
         core_lat     <= 1;
      end else if (core_busy) begin
         if (core_lat == 0) begin
            core_busy    <= 1'b0;
            pq_done      <= 1'b1;
            done_is_push <= core_push_op;
            if (core_push_op) begin
               core_q.push_back(int'(core_key));
               done_key <= core_key;
            end else begin
               pq_dout <= KEY_W'(pop_min());
            end
            core_n <= core_q.size();
         end else begin
            core_lat <= core_lat - 1;
         end
      end
   end

   // ---------------- expected display registers ----------------
   int               exp_cnt = 0;
   logic [KEY_W-1:0] exp_in = '0, exp_out = '0;
   logic             abandon = 1'b0;
   int               pop_log[$];
   int               push_log[$];

   always @(posedge clk) begin
      if (rst) begin
         exp_cnt <= 0;
         exp_in  <= '0;
         exp_out <= '0;
         abandon <= core_busy || pq_done || pq_push || pq_pop;
      end else if (pq_done) begin
         if (!abandon) begin
            if (done_is_push) begin
               exp_in  <= done_key;
               exp_cnt <= (exp_cnt < DEPTH) ? exp_cnt + 1 : DEPTH;
            end else begin
               exp_out <= pq_dout;
               exp_cnt <= (exp_cnt > 0) ? exp_cnt - 1 : 0;
               pop_log.push_back(int'(pq_dout));
            end
         end
         abandon <= 1'b0;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic auto_mode = 1'b0;
   logic prev_push = 1'b0, prev_pop = 1'b0;
   int   n_push = 0, n_pop = 0;
   logic busy_push;

   always @(negedge clk) begin
      if (!rst) begin
         chk("sig_onehot", $countones({sigIDLE, sigADD, sigREMOVE, sigDISPLAY, sigFULL, sigEMPTY}), 1);
         chk("disp_cnt", int'(disp_cnt), exp_cnt);
         chk("disp_in", int'(disp_in), int'(exp_in));
         chk("disp_out", int'(disp_out), int'(exp_out));
         chk("push_pop_excl", int'(pq_push & pq_pop), 0);
         if ((core_busy || pq_done) && !abandon) begin
            busy_push = core_busy ? core_push_op : done_is_push;
            chk("busy_sigADD", int'(sigADD), int'(busy_push));
            chk("busy_sigREMOVE", int'(sigREMOVE), int'(!busy_push));
            chk("busy_rgb", int'({rgb_r, rgb_g, rgb_b}), busy_push ? 9'o070 : 9'o007);
         end
         if (pq_push) begin
            chk("push_one_cycle", int'(prev_push), 0);
            if (!auto_mode) chk("push_key", int'(pq_key), int'(sw_key));
            n_push++;
            push_log.push_back(int'(pq_key));
         end
         if (pq_pop) begin
            chk("pop_one_cycle", int'(prev_pop), 0);
            n_pop++;
         end
`ifndef PQ_AUTO_EN
         chk("sigSTART_tied", int'(sigSTART), 0);
`endif
      end
      prev_push = pq_push;
      prev_pop  = pq_pop;
   end

   // ---------------- helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic a, input logic r, input logic s, input int hold);
      btn_add = a; btn_remove = r; btn_start = s;
      cyc(hold);
      btn_add = 1'b0; btn_remove = 1'b0; btn_start = 1'b0;
   endtask

   function automatic logic sel(input int w);
      case (w)
         S_IDLE:    return sigIDLE;
         S_ADD:     return sigADD;
         S_REMOVE:  return sigREMOVE;
         S_DISPLAY: return sigDISPLAY;
         S_FULL:    return sigFULL;
         S_EMPTY:   return sigEMPTY;
         S_START:   return sigSTART;
         default:   return 1'b0;
      endcase
   endfunction

   task automatic wait_level(input string name, input int w, input logic lvl, input int budget);
      int i = 0;
      while (sel(w) != lvl && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (sel(w) != lvl) chk(name, int'(sel(w)), int'(lvl));
   endtask

   task automatic hold_len(input int w, output int n);
      n = 0;
      while (sel(w) && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_push(input int budget);
      int i = 0;
      while (!pq_push && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (!pq_push) chk("wait_push_timeout", 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int p0, q0, len;
      bit ok;

      // reset state
      cyc(3);
      chk("rst_sigIDLE", int'(sigIDLE), 1);
      chk("rst_rgb", int'({rgb_r, rgb_g, rgb_b}), 9'o001);
      chk("rst_push_pop", int'({pq_push, pq_pop}), 0);
      chk("rst_pq_key", int'(pq_key), 0);
      chk("rst_disp", int'({disp_in, disp_out, disp_cnt}), 0);
      chk("rst_sigs", int'({sigSTART, sigADD, sigREMOVE, sigDISPLAY, sigFULL, sigEMPTY}), 0);
      rst = 1'b0;
      cyc(2);

      // single manual push of key 5
      sw_key = 4'd5;
      p0 = n_push;
      press(1, 0, 0, 6);
      wait_level("t_add_display_timeout", S_DISPLAY, 1'b1, 60);
      chk("add_disp_in", int'(disp_in), 5);
      chk("add_disp_cnt", int'(disp_cnt), 1);
      chk("add_rgb_display", int'({rgb_r, rgb_g, rgb_b}), 9'o040);
      hold_len(S_DISPLAY, len);
      chk("add_display_len", len, DISP);
      chk("add_back_idle", int'(sigIDLE), 1);
      chk("add_push_count", n_push - p0, 1);
      chk("add_pushed_key", push_log[push_log.size()-1], 5);

      // bounce shorter than the debounce window, then a clean press
      sw_key = 4'd9;
      p0 = n_push;
      press(1, 0, 0, 3); cyc(2);
      press(1, 0, 0, 2); cyc(3);
      press(1, 0, 0, 3); cyc(30);
      chk("bounce_no_push", n_push - p0, 0);
      chk("bounce_idle", int'(sigIDLE), 1);
      press(1, 0, 0, 10);
      wait_level("t_clean_display_timeout", S_DISPLAY, 1'b1, 60);
      hold_len(S_DISPLAY, len);
      chk("clean_one_push", n_push - p0, 1);
      chk("clean_disp_in", int'(disp_in), 9);
      chk("clean_disp_cnt", int'(disp_cnt), 2);

      // refused push and refused pop
      force_full = 1'b1;
      p0 = n_push;
      press(1, 0, 0, 6);
      wait_level("t_full_timeout", S_FULL, 1'b1, 60);
      chk("full_rgb", int'({rgb_r, rgb_g, rgb_b}), 9'o700);
      hold_len(S_FULL, len);
      chk("full_len", len, DISP);
      chk("full_no_push", n_push - p0, 0);
      force_full = 1'b0;
      cyc(2);
      force_empty = 1'b1;
      q0 = n_pop;
      press(0, 1, 0, 6);
      wait_level("t_empty_timeout", S_EMPTY, 1'b1, 60);
      chk("empty_rgb", int'({rgb_r, rgb_g, rgb_b}), 9'o707);
      hold_len(S_EMPTY, len);
      chk("empty_len", len, DISP);
      chk("empty_no_pop", n_pop - q0, 0);
      chk("empty_back_idle", int'(sigIDLE), 1);
      force_empty = 1'b0;
      cyc(2);

      // simultaneous add+remove resolves as remove; core holds {5,9}
      p0 = n_push; q0 = n_pop;
      press(1, 1, 0, 6);
      wait_level("t_both_display_timeout", S_DISPLAY, 1'b1, 60);
      chk("both_disp_out", int'(disp_out), 5);
      chk("both_disp_cnt", int'(disp_cnt), 1);
      hold_len(S_DISPLAY, len);
      chk("both_no_push", n_push - p0, 0);
      chk("both_one_pop", n_pop - q0, 1);

      // remove pressed while busy is discarded
      sw_key = 4'd3;
      p0 = n_push; q0 = n_pop;
      btn_add = 1'b1;
      wait_push(40);
      btn_add = 1'b0;
      btn_remove = 1'b1;
      cyc(6);
      btn_remove = 1'b0;
      wait_level("t_discard_idle_timeout", S_IDLE, 1'b1, 60);
      cyc(30);
      chk("discard_no_pop", n_pop - q0, 0);
      chk("discard_one_push", n_push - p0, 1);
      chk("discard_disp_in", int'(disp_in), 3);
      chk("discard_disp_cnt", int'(disp_cnt), 2);

      // reset while waiting abandons the op; the late pq_done is ignored
      sw_key = 4'd2;
      btn_add = 1'b1;
      wait_push(40);
      btn_add = 1'b0;
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(15);
      chk("rstwait_idle", int'(sigIDLE), 1);
      chk("rstwait_disp_in", int'(disp_in), 0);
      chk("rstwait_disp_cnt", int'(disp_cnt), 0);
      chk("rstwait_core_n", core_n, 3);

      // pop with disp_cnt already 0 saturates; core holds {9,3,2}
      q0 = n_pop;
      press(0, 1, 0, 6);
      wait_level("t_sat_display_timeout", S_DISPLAY, 1'b1, 60);
      chk("sat_disp_out", int'(disp_out), 2);
      chk("sat_disp_cnt", int'(disp_cnt), 0);
      hold_len(S_DISPLAY, len);
      chk("sat_one_pop", n_pop - q0, 1);

`ifdef PQ_AUTO_EN
      // drain {9,3}, then run the auto demo from an empty core
      repeat (2) begin
         press(0, 1, 0, 6);
         wait_level("t_drain_display_timeout", S_DISPLAY, 1'b1, 60);
         hold_len(S_DISPLAY, len);
      end
      chk("drain_core_empty", core_n, 0);
      cyc(4);
      pop_log.delete();
      push_log.delete();
      p0 = n_push; q0 = n_pop;
      auto_mode = 1'b1;
      press(0, 0, 1, 6);
      wait_level("t_auto_start_timeout", S_START, 1'b1, 40);
      chk("auto_start_high", int'(sigSTART), 1);
      wait_level("t_auto_end_timeout", S_START, 1'b0, 3000);
      chk("auto_pushes", n_push - p0, DEPTH);
      chk("auto_pops", n_pop - q0, DEPTH);
      chk("auto_pop_log_size", pop_log.size(), DEPTH);
      ok = 1'b1;
      for (int i = 1; i < pop_log.size(); i++)
         if (pop_log[i] < pop_log[i-1]) ok = 1'b0;
      chk("auto_pops_nondecreasing", int'(ok), 1);
      push_log.sort();
      ok = (push_log.size() == pop_log.size());
      for (int i = 0; i < push_log.size() && i < pop_log.size(); i++)
         if (push_log[i] != pop_log[i] || push_log[i] == 0) ok = 1'b0;
      for (int i = 1; i < push_log.size(); i++)
         if (push_log[i] == push_log[i-1]) ok = 1'b0;
      chk("auto_keys_distinct_popped", int'(ok), 1);
      chk("auto_end_idle", int'(sigIDLE), 1);
      auto_mode = 1'b0;
`else
      // start button has no effect without the auto feature
      p0 = n_push; q0 = n_pop;
      press(0, 0, 1, 6);
      cyc(30);
      chk("start_ignored_sig", int'(sigSTART), 0);
      chk("start_ignored_ops", (n_push - p0) + (n_pop - q0), 0);
      chk("start_ignored_idle", int'(sigIDLE), 1);
`endif

      cyc(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
